tb_stream_checker: RTL and testbench

TB_STREAM_CHECKER -- requirements
Module: tb_stream_checker

---
 rtl/tb_stream_checker.sv | 123 ++++++++++++
 tb/tb_tb_stream_checker.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tb_stream_checker.sv
// Stream sink that checks received words against an expected vector, applies a
// fixed backpressure pattern and flags data mismatches, handshake abuse and stalls.
//
// state | meaning
// RUN   | accepting words, comparing, protocol and stall checks active
// DONE  | all DATA_COUNT words received; holds until reset
// TOUT  | TIMEOUT consecutive cycles without a transfer; holds until reset
module tb_stream_checker #(
  parameter int DATA_WIDTH = 1,
  parameter int DATA_COUNT = 1,
  parameter int PATTERN_LEN = 1,
  parameter logic [PATTERN_LEN-1:0] READY_PATTERN = '1,
  parameter int TIMEOUT = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH*DATA_COUNT-1:0] expect_i,
  input  logic                             dvld_i,
  input  logic [DATA_WIDTH-1:0]            ddat_i,
  output logic                             drdy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic [$clog2(DATA_COUNT+1)-1:0]  err_cnt_o,
  output logic [$clog2(DATA_COUNT+1)-1:0]  err_idx_o,
  output logic [DATA_WIDTH-1:0]            err_dat_o,
  output logic                             proto_err_o,
  output logic                             timeout_o,
  output logic                             pass_o
);

  localparam int CW = $clog2(DATA_COUNT + 1);
  localparam int PW = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;
  localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {RUN, DONE, TOUT} state_t;

  state_t                state;
  logic [PW-1:0]         pat_ptr;
  logic [CW-1:0]         ptr;
  logic [SW-1:0]         stall_left;
  logic                  pend;
  logic [DATA_WIDTH-1:0] pend_dat;

  logic                  xfer;
  logic                  mism;
  logic                  last;
  logic                  stall_tc;
  logic                  proto_bad;
  logic [DATA_WIDTH-1:0] exp_word;
  logic                  done_n;
  logic                  err_n;
  logic                  proto_n;
  logic                  tout_n;

  assign drdy_o = !reset && (state == RUN) && READY_PATTERN[pat_ptr];

  always_comb begin
    exp_word  = expect_i[int'(ptr)*DATA_WIDTH +: DATA_WIDTH];
    xfer      = dvld_i && drdy_o;
    mism      = xfer && (ddat_i != exp_word);
    last      = xfer && (ptr == CW'(DATA_COUNT - 1));
    // Stall timer counts down from TIMEOUT; terminal count is the last idle cycle.
    stall_tc  = (TIMEOUT != 0) && (state == RUN) && !xfer && (stall_left == SW'(1));
    proto_bad = (state == RUN) && pend && (!dvld_i || (ddat_i != pend_dat));
    done_n    = done_o | last;
    err_n     = err_o | mism;
    proto_n   = proto_err_o | proto_bad;
    tout_n    = timeout_o | stall_tc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pat_ptr     <= '0;
      ptr         <= '0;
      stall_left  <= SW'(TIMEOUT);
      pend        <= 1'b0;
      pend_dat    <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_cnt_o   <= '0;
      err_idx_o   <= '0;
      err_dat_o   <= '0;
      proto_err_o <= 1'b0;
      timeout_o   <= 1'b0;
      pass_o      <= 1'b0;
    end else begin
      if (pat_ptr == PW'(PATTERN_LEN - 1)) pat_ptr <= '0;
      else                                 pat_ptr <= pat_ptr + 1'b1;

      pend     <= (state == RUN) && dvld_i && !drdy_o;
      pend_dat <= ddat_i;

      case (state)
        RUN: begin
          if (xfer) begin
            ptr        <= ptr + 1'b1;
            stall_left <= SW'(TIMEOUT);
            if (mism) begin
              if (err_cnt_o != CW'(DATA_COUNT)) err_cnt_o <= err_cnt_o + 1'b1;
              if (!err_o) begin
                err_idx_o <= ptr;
                err_dat_o <= ddat_i;
              end
            end
          end else if (TIMEOUT != 0) begin
            stall_left <= stall_left - 1'b1;
          end
          if (last)          state <= DONE;
          else if (stall_tc) state <= TOUT;
        end
        default: ;
      endcase

      done_o      <= done_n;
      err_o       <= err_n;
      proto_err_o <= proto_n;
      timeout_o   <= tout_n;
      pass_o      <= done_n && !err_n && !proto_n && !tout_n;
    end
  end

endmodule

// File: tb/tb_tb_stream_checker.sv
// Randomized bench for tb_stream_checker: a well-behaved (or deliberately faulty)
// source drives streams, a word-counting reference model predicts every output.
module tb_tb_stream_checker;
  localparam int DW = 8;
  localparam int DC = 4;
  localparam int PL = 3;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DW*DC-1:0]  expect_i = '0;
  logic              dvld_i = 1'b0;
  logic [DW-1:0]     ddat_i = '0;
  logic              drdy_o, done_o, err_o, proto_err_o, timeout_o, pass_o;
  logic [2:0]        err_cnt_o, err_idx_o;
  logic [DW-1:0]     err_dat_o;

  tb_stream_checker #(
    .DATA_WIDTH(DW), .DATA_COUNT(DC), .PATTERN_LEN(PL),
    .READY_PATTERN(3'b101), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .expect_i(expect_i), .dvld_i(dvld_i), .ddat_i(ddat_i),
    .drdy_o(drdy_o), .done_o(done_o), .err_o(err_o), .err_cnt_o(err_cnt_o),
    .err_idx_o(err_idx_o), .err_dat_o(err_dat_o), .proto_err_o(proto_err_o),
    .timeout_o(timeout_o), .pass_o(pass_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: words received since reset, idle run length, sticky flags.
  logic [PL-1:0] pat_v = 3'b101;
  int       m_cyc, m_nrx, m_idle, m_ecnt, m_eidx;
  logic [7:0] m_edat, m_pd;
  bit       m_done, m_err, m_proto, m_tout, m_pend;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit v, input logic [7:0] d, output bit xf);
    bit rdy;
    logic [7:0] w;
    @(negedge clk);
    reset = rst; dvld_i = v; ddat_i = d;
    #1;
    rdy = !rst && !m_done && !m_tout && pat_v[m_cyc % PL];
    check_val("drdy", drdy_o, rdy);
    xf = 1'b0;
    if (rst) begin
      m_cyc = 0; m_nrx = 0; m_idle = 0; m_ecnt = 0; m_eidx = 0; m_edat = 0; m_pd = 0;
      m_done = 0; m_err = 0; m_proto = 0; m_tout = 0; m_pend = 0;
    end else begin
      if (!m_done && !m_tout) begin
        if (m_pend && (!v || d != m_pd)) m_proto = 1;
        xf = v && rdy;
        if (xf) begin
          w = expect_i[m_nrx*8 +: 8];
          if (d != w) begin
            if (!m_err) begin m_eidx = m_nrx; m_edat = d; end
            m_err = 1;
            if (m_ecnt < DC) m_ecnt++;
          end
          m_nrx++;
          m_idle = 0;
          if (m_nrx == DC) m_done = 1;
        end else begin
          m_idle++;
          if (m_idle == TO) m_tout = 1;
        end
        m_pend = v && !rdy;
        m_pd = d;
      end else begin
        m_pend = 0;
      end
      m_cyc++;
    end
    @(posedge clk);
    #1;
    check_val("done", done_o, m_done);
    check_val("err", err_o, m_err);
    check_val("err_cnt", err_cnt_o, m_ecnt);
    check_val("err_idx", err_idx_o, m_eidx);
    check_val("err_dat", err_dat_o, m_edat);
    check_val("proto_err", proto_err_o, m_proto);
    check_val("timeout", timeout_o, m_tout);
    check_val("pass", pass_o, m_done && !m_err && !m_proto && !m_tout);
  endtask

  // Source sends snd word by word; holds a refused word unless inj corrupts it.
  task automatic run_stream(input logic [31:0] snd, input logic [31:0] exw,
                            input int vprob, input bit inj, input int rst_at);
    bit xf, v, hold, did_rst;
    logic [7:0] d;
    int src_idx, cyc;
    expect_i = exw;
    step(1, 0, 8'h00, xf);
    step(1, 0, 8'h00, xf);
    src_idx = 0; hold = 0; did_rst = 0; cyc = 0;
    while (!(m_done || m_tout) && cyc < 200) begin
      cyc++;
      if (rst_at > 0 && !did_rst && m_nrx == rst_at) begin
        step(1, 1, 8'hff, xf);
        did_rst = 1; src_idx = 0; hold = 0;
        continue;
      end
      if (hold) begin
        v = 1; d = snd[src_idx*8 +: 8];
        if (inj && $urandom_range(3) == 0) begin
          if ($urandom_range(1) == 1) v = 0;
          else d = d ^ 8'h01;
        end
      end else begin
        v = ($urandom_range(99) < vprob);
        d = v ? snd[src_idx*8 +: 8] : 8'($urandom);
      end
      step(0, v, d, xf);
      if (xf) begin
        if (src_idx < DC - 1) src_idx++;
        hold = 0;
      end else begin
        hold = v;
      end
    end
    check_val("stream_end", m_done || m_tout, 1);
    for (int i = 0; i < 3; i++) step(0, 1'($urandom_range(1)), 8'($urandom), xf);
  endtask

  initial begin
    bit xf;
    logic [31:0] e, s;
    step(1, 0, 8'h00, xf);
    step(1, 0, 8'h00, xf);
    run_stream(32'h84838281, 32'h84838281, 100, 0, 0);
    run_stream(32'h84938281, 32'h84838281, 100, 0, 0);
    run_stream(32'h84838281, 32'h84838281, 100, 0, 2);
    run_stream(32'h84838281, 32'h84838281, 0, 0, 0);
    run_stream(32'h84838281, 32'h84838281, 100, 0, 0);
    for (int i = 0; i < 4; i++) run_stream(32'h44332211, 32'h44332211, 100, 1, 0);
    for (int i = 0; i < 25; i++) begin
      e = $urandom;
      s = ($urandom_range(1) == 1) ? e : (e ^ (32'h1 << $urandom_range(31)));
      if ($urandom_range(3) == 0) s = s ^ (32'h1 << $urandom_range(31));
      run_stream(s, e, $urandom_range(100, 30), ($urandom_range(4) == 0), 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

endmodule
